// File: rtl/sc1602_pkg.sv
// Shared definitions for the SC1602 (HD44780-compatible) read path:
// FSM state encoding, timing defaults, busy-flag position and RS codes.
package sc1602_pkg;

    // Read-cycle FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HI_H  = 3'd2,
        ST_LO_H  = 3'd3,
        ST_HI_L  = 3'd4,
        ST_LO_L  = 3'd5,
        ST_DONE  = 3'd6
    } rd_state_t;

    // Timing defaults in sys_clk cycles
    localparam int DEF_T_AS     = 2;
    localparam int DEF_T_EH     = 8;
    localparam int DEF_T_EL     = 8;
    localparam int DEF_POLL_MAX = 1024;

    // Busy flag position inside a status byte
    localparam int BF_BIT = 7;

    // RS encodings
    localparam logic RS_INSTR = 1'b0;
    localparam logic RS_DATA  = 1'b1;

    // Largest of three timing values, used to size the timing counters
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sc1602_nibble_strobe.sv
// One E strobe for a 4-bit LCD read: T_EH cycles high, then T_EL cycles low.
// The pad nibble is captured on the last high cycle; o_done pulses on the
// last low cycle so the caller can chain the next strobe with no gap.
module sc1602_nibble_strobe
    import sc1602_pkg::*;
#(
    parameter int T_EH  = DEF_T_EH,
    parameter int T_EL  = DEF_T_EL,
    parameter int CNT_W = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [3:0] i_data,
    output logic       o_enable,
    output logic       o_highLast,
    output logic       o_done,
    output logic [3:0] o_nibble
);

    logic             r_enable;
    logic             r_lowActive;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_nibble;

    logic             w_highLast;
    logic             w_lowLast;

    assign w_highLast = r_enable    && (r_cnt == CNT_W'(T_EH - 1));
    assign w_lowLast  = r_lowActive && (r_cnt == CNT_W'(T_EL - 1));

    // Phase sequencing: a start always wins, so back-to-back strobes abut
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_enable    <= 1'b0;
            r_lowActive <= 1'b0;
            r_cnt       <= '0;
            r_nibble    <= 4'h0;
        end else if (i_start) begin
            r_enable    <= 1'b1;
            r_lowActive <= 1'b0;
            r_cnt       <= '0;
        end else if (w_highLast) begin
            r_enable    <= 1'b0;
            r_lowActive <= 1'b1;
            r_cnt       <= '0;
            r_nibble    <= i_data;
        end else if (w_lowLast) begin
            r_lowActive <= 1'b0;
            r_cnt       <= '0;
        end else if (r_enable || r_lowActive) begin
            r_cnt       <= r_cnt + CNT_W'(1);
        end
    end

    assign o_enable   = r_enable;
    assign o_highLast = w_highLast;
    assign o_done     = w_lowLast;
    assign o_nibble   = r_nibble;

endmodule

// File: rtl/sc1602_reader.sv
// SC1602 4-bit read engine: status (busy flag / address) and data reads,
// plus a poll mode that repeats status reads until the busy flag clears.
// All LCD pins are driven straight from flops so E never glitches.
module sc1602_reader
    import sc1602_pkg::*;
#(
    parameter int T_AS     = DEF_T_AS,
    parameter int T_EH     = DEF_T_EH,
    parameter int T_EL     = DEF_T_EL,
    parameter int POLL_MAX = DEF_POLL_MAX
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic       req_poll,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_busy,
    output logic [6:0] rsp_addr,
    output logic       rsp_timeout,
    output logic       bus_active,
    output logic       sc1602_rs,
    output logic       sc1602_rw,
    output logic       sc1602_enable,
    input  logic [3:0] sc1602_data_i,
    output logic       sc1602_data_oe
);

    localparam int CNT_W  = $clog2(max3(T_AS, T_EH, T_EL) + 1);
    localparam int PCNT_W = $clog2(POLL_MAX + 1);

    rd_state_t         r_state;
    logic [CNT_W-1:0]  r_setupCnt;
    logic [PCNT_W-1:0] r_pollCnt;
    logic              r_poll;
    logic              r_rs;
    logic              r_rw;
    logic              r_ready;
    logic              r_busActive;
    logic [3:0]        r_highNib;
    logic              r_rspValid;
    logic [7:0]        r_rspData;
    logic              r_rspBusy;
    logic [6:0]        r_rspAddr;
    logic              r_rspTimeout;

    logic              w_accept;
    logic              w_setupLast;
    logic              w_start;
    logic              w_enable;
    logic              w_highLast;
    logic              w_done;
    logic [3:0]        w_nibble;
    logic              w_bf;
    logic              w_again;
    logic              w_finish;
    logic [7:0]        w_byte;

    assign w_accept    = (r_state == ST_IDLE) && req_valid && r_ready;
    assign w_setupLast = (r_setupCnt == CNT_W'(T_AS - 1));
    assign w_bf        = r_highNib[BF_BIT - 4];
    assign w_again     = r_poll && w_bf && (r_pollCnt < PCNT_W'(POLL_MAX));
    assign w_finish    = (r_state == ST_LO_L) && w_done && !w_again;
    assign w_byte      = {r_highNib, w_nibble};

    // Kick a strobe after setup, between the two nibbles, and for each poll retry
    assign w_start = ((r_state == ST_SETUP) && w_setupLast)
                  || ((r_state == ST_LO_H)  && w_done)
                  || ((r_state == ST_LO_L)  && w_done && w_again);

    sc1602_nibble_strobe #(
        .T_EH  (T_EH),
        .T_EL  (T_EL),
        .CNT_W (CNT_W)
    ) u_strobe (
        .i_clk      (sys_clk),
        .i_rst      (sys_rst),
        .i_start    (w_start),
        .i_data     (sc1602_data_i),
        .o_enable   (w_enable),
        .o_highLast (w_highLast),
        .o_done     (w_done),
        .o_nibble   (w_nibble)
    );

    // Main read-cycle state machine; strobe events drive the nibble phases
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= ST_IDLE;
            r_poll    <= 1'b0;
            r_highNib <= 4'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_SETUP;
                        r_poll  <= req_poll;
                    end
                end
                ST_SETUP: begin
                    if (w_setupLast) r_state <= ST_HI_H;
                end
                ST_HI_H: begin
                    if (w_highLast) r_state <= ST_LO_H;
                end
                ST_LO_H: begin
                    if (w_done) begin
                        r_highNib <= w_nibble;
                        r_state   <= ST_HI_L;
                    end
                end
                ST_HI_L: begin
                    if (w_highLast) r_state <= ST_LO_L;
                end
                ST_LO_L: begin
                    if (w_done) r_state <= w_again ? ST_HI_H : ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // RS/RW setup time counter, restarted for every accepted request
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_setupCnt <= '0;
        end else if (w_accept) begin
            r_setupCnt <= '0;
        end else if ((r_state == ST_SETUP) && !w_setupLast) begin
            r_setupCnt <= r_setupCnt + CNT_W'(1);
        end else if (r_state == ST_SETUP) begin
            r_setupCnt <= '0;
        end
    end

    // Status reads issued in poll mode, 1..POLL_MAX, saturating by construction
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_pollCnt <= '0;
        end else if (w_accept) begin
            r_pollCnt <= PCNT_W'(1);
        end else if ((r_state == ST_LO_L) && w_done && w_again) begin
            r_pollCnt <= r_pollCnt + PCNT_W'(1);
        end
    end

    // RS/RW and bus ownership: set on acceptance, released when entering DONE
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_rs        <= 1'b0;
            r_rw        <= 1'b0;
            r_busActive <= 1'b0;
        end else if (w_accept) begin
            r_rs        <= (req_rs && !req_poll) ? RS_DATA : RS_INSTR;
            r_rw        <= 1'b1;
            r_busActive <= 1'b1;
        end else if (w_finish) begin
            r_rs        <= 1'b0;
            r_rw        <= 1'b0;
            r_busActive <= 1'b0;
        end
    end

    // Ready is registered so it stays low throughout reset and rises right after
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_ready <= 1'b0;
        end else if (w_accept) begin
            r_ready <= 1'b0;
        end else if ((r_state == ST_IDLE) || (r_state == ST_DONE)) begin
            r_ready <= 1'b1;
        end
    end

    // Response capture on the way into DONE; fields hold until the next response
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_rspValid   <= 1'b0;
            r_rspData    <= 8'h00;
            r_rspBusy    <= 1'b0;
            r_rspAddr    <= 7'h00;
            r_rspTimeout <= 1'b0;
        end else if (w_finish) begin
            r_rspValid   <= 1'b1;
            r_rspData    <= w_byte;
            r_rspBusy    <= (r_rs == RS_INSTR) ? w_byte[BF_BIT] : 1'b0;
            r_rspAddr    <= (r_rs == RS_INSTR) ? w_byte[6:0] : 7'h00;
            r_rspTimeout <= r_poll && w_bf;
        end else begin
            r_rspValid   <= 1'b0;
        end
    end

    assign req_ready      = r_ready;
    assign rsp_valid      = r_rspValid;
    assign rsp_data       = r_rspData;
    assign rsp_busy       = r_rspBusy;
    assign rsp_addr       = r_rspAddr;
    assign rsp_timeout    = r_rspTimeout;
    assign bus_active     = r_busActive;
    assign sc1602_rs      = r_rs;
    assign sc1602_rw      = r_rw;
    assign sc1602_enable  = w_enable;
    assign sc1602_data_oe = 1'b0;

endmodule

// File: tb/tb_sc1602_reader.sv
// Self-checking bench for sc1602_reader. An LCD model hands out queued
// nibbles on each E rise and scrambles the bus on each E fall; expected
// responses, latencies and E waveforms are computed from the read rules.
module tb_sc1602_reader;

    localparam int T_AS     = 2;
    localparam int T_EH     = 8;
    localparam int T_EL     = 8;
    localparam int POLL_MAX = 4;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rs = 1'b0;
    logic       req_poll = 1'b0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_busy;
    logic [6:0] rsp_addr;
    logic       rsp_timeout;
    logic       bus_active;
    logic       sc1602_rs;
    logic       sc1602_rw;
    logic       sc1602_enable;
    logic [3:0] sc1602_data_i = 4'h0;
    logic       sc1602_data_oe;

    int         testCount = 0;
    int         failCount = 0;
    int         oeHighCount = 0;
    int         waitCycles;
    logic [7:0] readBytes[$];
    logic [3:0] lcdQ[$];
    logic [7:0] lastData = 8'h00;

    sc1602_reader #(
        .T_AS     (T_AS),
        .T_EH     (T_EH),
        .T_EL     (T_EL),
        .POLL_MAX (POLL_MAX)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_rs         (req_rs),
        .req_poll       (req_poll),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_busy       (rsp_busy),
        .rsp_addr       (rsp_addr),
        .rsp_timeout    (rsp_timeout),
        .bus_active     (bus_active),
        .sc1602_rs      (sc1602_rs),
        .sc1602_rw      (sc1602_rw),
        .sc1602_enable  (sc1602_enable),
        .sc1602_data_i  (sc1602_data_i),
        .sc1602_data_oe (sc1602_data_oe)
    );

    // 100 MHz system clock
    always #5 sys_clk = ~sys_clk;

    // LCD model: present the next queued nibble while E is high, garbage otherwise
    always @(sc1602_enable) begin
        if (sc1602_enable) begin
            if (lcdQ.size() > 0) sc1602_data_i = lcdQ.pop_front();
            else                 sc1602_data_i = 4'($urandom);
        end else begin
            sc1602_data_i = 4'($urandom);
        end
    end

    // The read block must never drive the data pads
    always @(posedge sys_clk) begin
        #1;
        if (sc1602_data_oe !== 1'b0) oeHighCount++;
    end

    // Hard stop in case the bench itself gets stuck
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 500000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Issue one request over the bytes in readBytes and check the whole transfer
    task automatic applyStimulus(input logic rs, input logic poll, input bit keepValid,
                                 output int waits);
        int         nReads;
        int         latency;
        int         cyc;
        int         eRises;
        int         waveErr;
        int         foundAt;
        logic [7:0] finalByte;
        logic       rsEff;
        logic       prevE;
        logic       expE;

        nReads = 1;
        if (poll) begin
            while ((nReads < POLL_MAX) && readBytes[nReads - 1][7]) nReads++;
        end
        finalByte = readBytes[nReads - 1];
        rsEff     = rs & ~poll;
        latency   = T_AS + 2 * (T_EH + T_EL) * nReads + 1;

        lcdQ.delete();
        foreach (readBytes[i]) begin
            lcdQ.push_back(readBytes[i][7:4]);
            lcdQ.push_back(readBytes[i][3:0]);
        end

        waits = 0;
        while (!req_ready && (waits < 50)) begin
            @(posedge sys_clk); #1;
            waits++;
        end
        checkOutput("ready_before_req", 32'(req_ready), 32'd1);

        req_rs    = rs;
        req_poll  = poll;
        req_valid = 1'b1;
        @(posedge sys_clk); #1;
        if (!keepValid) req_valid = 1'b0;

        cyc     = 1;
        eRises  = 0;
        waveErr = 0;
        foundAt = 0;
        prevE   = 1'b0;
        while ((foundAt == 0) && (cyc <= latency + 40)) begin
            if (rsp_valid) begin
                foundAt = cyc;
            end else begin
                if (cyc < latency) begin
                    expE = (cyc >= T_AS + 1) && (((cyc - T_AS - 1) % (T_EH + T_EL)) < T_EH);
                    if ((sc1602_enable !== expE) || (sc1602_rs !== rsEff) ||
                        (sc1602_rw !== 1'b1) || (bus_active !== 1'b1) ||
                        (req_ready !== 1'b0) || (rsp_data !== lastData))
                        waveErr++;
                end
                if (sc1602_enable && !prevE) eRises++;
                prevE = sc1602_enable;
                @(posedge sys_clk); #1;
                cyc++;
            end
        end

        checkOutput("rsp_cycle",   32'(foundAt), 32'(latency));
        checkOutput("rsp_data",    32'(rsp_data), 32'(finalByte));
        checkOutput("rsp_busy",    32'(rsp_busy), rsEff ? 32'd0 : 32'(finalByte[7]));
        checkOutput("rsp_addr",    32'(rsp_addr), rsEff ? 32'd0 : 32'(finalByte[6:0]));
        checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(poll & finalByte[7]));
        checkOutput("e_pulses",    32'(eRises), 32'(2 * nReads));
        checkOutput("wave_errors", 32'(waveErr), 32'd0);
        checkOutput("done_pins",
                    32'({sc1602_enable, sc1602_rs, sc1602_rw, bus_active, req_ready}), 32'd0);
        lastData = finalByte;
    endtask

    // Start a data read, pulse reset at the given cycle and confirm it is abandoned
    task automatic resetMidRead(input int atCycle);
        int   cyc;
        int   seen;
        logic expE;

        lcdQ.delete();
        lcdQ.push_back(4'h9);
        lcdQ.push_back(4'hA);
        cyc = 0;
        while (!req_ready && (cyc < 50)) begin
            @(posedge sys_clk); #1;
            cyc++;
        end
        req_rs    = 1'b1;
        req_poll  = 1'b0;
        req_valid = 1'b1;
        @(posedge sys_clk); #1;
        req_valid = 1'b0;
        repeat (atCycle - 1) begin
            @(posedge sys_clk); #1;
        end
        expE = (atCycle >= T_AS + 1) && (((atCycle - T_AS - 1) % (T_EH + T_EL)) < T_EH);
        checkOutput("rst_pre_pins", 32'({sc1602_enable, sc1602_rs, sc1602_rw}),
                    32'({expE, 1'b1, 1'b1}));
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        checkOutput("rst_pins",
                    32'({sc1602_enable, sc1602_rs, sc1602_rw, bus_active, rsp_valid, req_ready}),
                    32'd0);
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;
        checkOutput("rst_ready", 32'(req_ready), 32'd1);
        seen = 0;
        repeat (48) begin
            if (rsp_valid) seen++;
            @(posedge sys_clk); #1;
        end
        checkOutput("rst_no_rsp", 32'(seen), 32'd0);
        checkOutput("rst_data", 32'(rsp_data), 32'd0);
        lastData = 8'h00;
    endtask

    // Test sequence: reset, directed reads, resets mid-read, back-to-back, random
    initial begin
        int  nBusy;
        logic rs;
        logic poll;

        repeat (3) @(posedge sys_clk);
        #1;
        checkOutput("reset_outputs",
                    32'({rsp_valid, rsp_data, rsp_busy, rsp_addr, rsp_timeout, bus_active,
                         sc1602_rs, sc1602_rw, sc1602_enable, req_ready}), 32'd0);
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;
        checkOutput("ready_after_reset", 32'(req_ready), 32'd1);

        readBytes = {8'h85};
        applyStimulus(1'b0, 1'b0, 1'b0, waitCycles);
        readBytes = {8'h41};
        applyStimulus(1'b1, 1'b0, 1'b0, waitCycles);
        readBytes = {8'h8A, 8'hC0, 8'hFF, 8'h03};
        applyStimulus(1'b1, 1'b1, 1'b0, waitCycles);
        readBytes = {8'h80, 8'h81, 8'h82, 8'h83, 8'h84};
        applyStimulus(1'b0, 1'b1, 1'b0, waitCycles);

        resetMidRead(15);
        resetMidRead(6);

        readBytes = {8'h5C};
        applyStimulus(1'b1, 1'b0, 1'b1, waitCycles);
        readBytes = {8'hA7};
        applyStimulus(1'b0, 1'b0, 1'b0, waitCycles);
        checkOutput("b2b_accept_wait", 32'(waitCycles), 32'd1);

        for (int t = 0; t < 16; t++) begin
            rs   = 1'($urandom_range(0, 1));
            poll = ($urandom_range(0, 2) == 0);
            readBytes.delete();
            if (poll) begin
                nBusy = $urandom_range(0, 5);
                for (int i = 0; i < nBusy; i++)
                    readBytes.push_back(8'h80 | 8'($urandom_range(0, 127)));
                readBytes.push_back(8'($urandom_range(0, 127)));
            end else begin
                readBytes.push_back(8'($urandom_range(0, 255)));
            end
            applyStimulus(rs, poll, 1'b0, waitCycles);
        end

        checkOutput("data_oe_high_cycles", 32'(oeHighCount), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/sc1602_reader.md
# sc1602_reader

Read-side companion to the SC1602 (HD44780-compatible) 4-bit write path. Performs LCD read cycles (RW=1) in 4-bit mode: busy-flag/address-counter reads (RS=0) and DDRAM/CGRAM data reads (RS=1). Also offers a poll-until-not-busy mode. Sits beside the write driver on the shared sc1602 pins; an external pin mux selects this block while `bus_active`=1.

## Interface
- `T_AS`, default 2: sys_clk cycles of RS/RW setup before the first E rise (≥40 ns).
- `T_EH`, default 8: E high cycles per nibble (≥230 ns, covers tDDR).
- `T_EL`, default 8: E low cycles per nibble (E cycle ≥500 ns, covers tAH).
- `POLL_MAX`, default 1024: maximum status reads in poll mode before timeout; ≥1.
- `sys_clk  in  1`: the single clock.
- `sys_rst  in  1`: synchronous, active-high reset.
- `req_valid  in  1`: request strobe.
- `req_ready  out  1`: high only in IDLE; a request is accepted on `req_valid & req_ready`.
- `req_rs  in  1`: 0 = status read, 1 = data read. Ignored when `req_poll`=1.
- `req_poll  in  1`: 1 = repeat status reads until BF=0.
- `rsp_valid  out  1`: one-cycle pulse; the response fields are valid in that cycle.
- `rsp_data  out  8`: assembled byte, {high nibble, low nibble}.
- `rsp_busy  out  1`: `rsp_data[7]` when the read was a status read, else 0.
- `rsp_addr  out  7`: `rsp_data[6:0]` when the read was a status read, else 0.
- `rsp_timeout  out  1`: poll ended after `POLL_MAX` reads with BF still 1.
- `bus_active  out  1`: high from acceptance through the end of the last E-low period.
- `sc1602_rs  out  1`: LCD RS.
- `sc1602_rw  out  1`: LCD RW.
- `sc1602_enable  out  1`: LCD E.
- `sc1602_data_i  in  4`: DB7..DB4, sampled from the pad input.
- `sc1602_data_oe  out  1`: data-pad output enable; constant 0 from this block (the FPGA never drives DB while reading).

## Operation
- States: IDLE, SETUP, HI_H, LO_H, HI_L, LO_L, DONE.
- IDLE → SETUP on handshake. Request fields are latched. The effective RS is `req_rs & ~req_poll`.
- SETUP:
  - Hold RS/RW=1 for `T_AS` cycles with E=0.
  - Then HI_H for `T_EH` cycles with E=1.
  - Sample `sc1602_data_i` into the high nibble on the last HI_H cycle.
- LO_H (`T_EL` cycles, E=0) → HI_L (`T_EH` cycles; sample the low nibble on its last cycle) → LO_L (`T_EL` cycles).
- LO_L end, poll mode only:
  - If BF=1 and reads < `POLL_MAX`: increment the read count and go directly to HI_H (no new SETUP).
  - Otherwise go to DONE.
- LO_L end, non-poll mode: go to DONE.
- DONE: one cycle with `rsp_valid`=1, RW=0, RS=0, `bus_active`=0. Next state is IDLE.
- Response fields hold their values until the next `rsp_valid`.
- `rsp_timeout`=1 only when BF=1 on read number `POLL_MAX`.
- Timing counter width is ceil(log2(max(`T_AS`,`T_EH`,`T_EL`)+1)). The poll counter counts 1..`POLL_MAX` and never wraps.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
  - `req_ready` is 0 during reset and 1 in the first cycle after reset.
- Reset asserted mid-cycle: E drops to 0 on the next edge, and RS/RW return to 0 on the same edge.
  - No `rsp_valid` is produced and the partial byte is discarded.
  - Read-ahead address side effects on the LCD are the user's concern.
- Handshake at edge 0:
  - RS/RW valid from cycle 1.
  - E high during cycles `T_AS`+1 .. `T_AS`+`T_EH`.
- Single read: `rsp_valid` fires at cycle `T_AS`+2·(`T_EH`+`T_EL`)+1, which is 35 with the defaults.
- Each extra poll iteration adds 2·(`T_EH`+`T_EL`) cycles (32 with the defaults).
- `req_valid` held during a transfer is ignored, because `req_ready`=0. The earliest next acceptance is the cycle after DONE.
- RW stays 1 through all of LO_L, which guarantees address hold after the final E fall.

## Structure
- Package `sc1602_pkg` holds:
  - the state enum `rd_state_t`;
  - the timing defaults;
  - `BF_BIT`=7;
  - RS encodings `RS_INSTR`=0 and `RS_DATA`=1.
- Sub-module `sc1602_nibble_strobe`:
  - generates one E pulse of `T_EH` high and `T_EL` low cycles;
  - returns the sampled nibble plus a `done` pulse;
  - is instantiated once and reused for both nibbles and for every poll iteration.

## Test plan
- Status read, LCD model returns 0x8 then 0x5:
  - `rsp_valid` at cycle 35;
  - `rsp_data`=0x85, `rsp_busy`=1, `rsp_addr`=0x05;
  - RS=0 and RW=1 throughout.
- Data read (`req_rs`=1), model returns 0x4, 0x1:
  - `rsp_data`=0x41, `rsp_busy`=0, `rsp_addr`=0;
  - exactly two E pulses, each 8 cycles high and 8 cycles low.
- Poll mode, model BF=1 for 3 reads then 0x03:
  - 4 reads, no SETUP between them;
  - `rsp_valid` at cycle 35+3·32=131;
  - `rsp_data`=0x03, `rsp_timeout`=0.
- Poll with BF stuck at 1 and `POLL_MAX`=4:
  - exactly 4 E pulse pairs;
  - `rsp_timeout`=1, `rsp_busy`=1.
- `sys_rst` pulsed at cycle 15 of a read:
  - E, RS and RW are 0 at the next edge;
  - no `rsp_valid` is produced;
  - `req_ready`=1 in the first cycle after reset.
- Back-to-back requests with `req_valid` held high:
  - the second request is accepted one cycle after DONE;
  - `sc1602_data_oe` stays 0 for the whole run.
